// File: rtl/pipelined_multdiv_unit_pkg.sv
// Shared encodings for the iterative multiply/divide unit: op codes, FSM states
// and the iteration-count helper.
package pipelined_multdiv_unit_pkg;

  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_MULT = 2'b01,
    OP_DIV  = 2'b10,
    OP_ILL  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FIX  = 2'b10,
    ST_DONE = 2'b11
  } state_e;

  // Number of RUN cycles needed to walk all operand bits.
  function automatic int cyc_of(input int width, input int steps);
    return width / steps;
  endfunction

endpackage

// File: rtl/pipelined_multdiv_unit_multdiv_step.sv
// One unsigned iteration bit: shift-add for MULT, restoring shift-subtract for DIV.
// hi/lo hold the product halves (MULT) or remainder/dividend-quotient (DIV).
module multdiv_step
  import pipelined_multdiv_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  op_e              op,
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi_n,
  output logic [WIDTH-1:0] lo_n
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] diff;
  logic           ge;

  always_comb begin
    sum    = {1'b0, hi} + (lo[0] ? {1'b0, b} : '0);
    rem_sh = {hi, lo[WIDTH-1]};
    diff   = rem_sh - {1'b0, b};
    ge     = (rem_sh >= {1'b0, b});
    if (op == OP_MULT) begin
      hi_n = sum[WIDTH:1];
      lo_n = {sum[0], lo[WIDTH-1:1]};
    end else begin
      // Remainder stays below |b| <= 2^(WIDTH-1), so WIDTH bits always suffice.
      hi_n = ge ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
      lo_n = {lo[WIDTH-2:0], ge};
    end
  end

endmodule

// File: rtl/pipelined_multdiv_unit.sv
// Iterative signed multiply/divide unit with valid/ready handshakes, destination
// tag tracking for decode stalls, result hold until writeback, and flush.
module pipelined_multdiv_unit
  import pipelined_multdiv_unit_pkg::*;
#(
  parameter int WIDTH           = 32,
  parameter int TAG_W           = 5,
  parameter int STEPS_PER_CYCLE = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             busy,
  output logic [TAG_W-1:0] busy_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_exception
);

  localparam int CYC   = cyc_of(WIDTH, STEPS_PER_CYCLE);
  localparam int CNT_W = $clog2(CYC + 1);

  state_e           state;
  logic [CNT_W-1:0] cnt;

  op_e              op_q;
  logic             neg_q;
  logic             dz_q;
  logic [TAG_W-1:0] tag_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic             exc_q;

  logic signed [WIDTH-1:0] a_s;
  logic signed [WIDTH-1:0] b_s;
  logic [WIDTH-1:0]        a_mag;
  logic [WIDTH-1:0]        b_mag;
  logic                    legal;
  logic                    accept;
  logic                    div_zero;

  logic [WIDTH-1:0] hi_c [STEPS_PER_CYCLE+1];
  logic [WIDTH-1:0] lo_c [STEPS_PER_CYCLE+1];

  // True magnitude exceeds the signed range for the requested sign.
  function automatic logic mag_ovf(input logic is_mult, input logic neg,
                                   input logic [WIDTH-1:0] hi, input logic [WIDTH-1:0] lo);
    logic [WIDTH-1:0] min_mag;
    min_mag = {1'b1, {(WIDTH-1){1'b0}}};
    if (is_mult && (|hi)) return 1'b1;
    return neg ? (lo > min_mag) : lo[WIDTH-1];
  endfunction

  function automatic logic [WIDTH-1:0] apply_sign(input logic neg, input logic [WIDTH-1:0] mag);
    return neg ? (~mag + 1'b1) : mag;
  endfunction

  always_comb begin
    a_s      = in_a;
    b_s      = in_b;
    a_mag    = a_s[WIDTH-1] ? (~in_a + 1'b1) : in_a;
    b_mag    = b_s[WIDTH-1] ? (~in_b + 1'b1) : in_b;
    legal    = (in_op == OP_MULT) || (in_op == OP_DIV);
    accept   = (state == ST_IDLE) && in_valid && legal && !flush;
    div_zero = (in_op == OP_DIV) && (in_b == '0);
  end

  assign hi_c[0] = hi_q;
  assign lo_c[0] = lo_q;

  for (genvar i = 0; i < STEPS_PER_CYCLE; i++) begin : g_step
    multdiv_step #(.WIDTH(WIDTH)) u_step (
      .op   (op_q),
      .hi   (hi_c[i]),
      .lo   (lo_c[i]),
      .b    (b_q),
      .hi_n (hi_c[i+1]),
      .lo_n (lo_c[i+1])
    );
  end

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: if (accept) begin
          cnt   <= CNT_W'(CYC);
          // Divide-by-zero skips the iterations and resolves in FIX.
          state <= div_zero ? ST_FIX : ST_RUN;
        end
        ST_RUN: begin
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) state <= ST_FIX;
        end
        ST_FIX:  state <= ST_DONE;
        ST_DONE: if (out_ready) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (accept) begin
      op_q  <= op_e'(in_op);
      neg_q <= in_a[WIDTH-1] ^ in_b[WIDTH-1];
      dz_q  <= div_zero;
      tag_q <= in_tag;
      hi_q  <= '0;
      lo_q  <= a_mag;
      b_q   <= b_mag;
    end else if (state == ST_RUN) begin
      hi_q <= hi_c[STEPS_PER_CYCLE];
      lo_q <= lo_c[STEPS_PER_CYCLE];
    end
    if (state == ST_FIX) begin
      res_q <= dz_q ? '0 : apply_sign(neg_q, lo_q);
      exc_q <= dz_q | mag_ovf(op_q == OP_MULT, neg_q, hi_q, lo_q);
    end
  end

  always_comb begin
    in_ready      = (state == ST_IDLE);
    busy          = (state != ST_IDLE);
    busy_tag      = busy ? tag_q : '0;
    out_valid     = (state == ST_DONE);
    out_result    = out_valid ? res_q : '0;
    out_tag       = out_valid ? tag_q : '0;
    out_exception = out_valid ? exc_q : 1'b0;
  end

endmodule

// File: tb/tb_pipelined_multdiv_unit.sv
// Directed bench for pipelined_multdiv_unit: 32-bit single-step instance plus a
// two-steps-per-cycle instance for the short-latency divide.
module tb_pipelined_multdiv_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid, in_valid_2;
  logic [1:0]  in_op;
  logic [31:0] in_a, in_b;
  logic [4:0]  in_tag;
  logic        flush;
  logic        out_ready, out_ready_2;

  logic        in_ready, busy, out_valid, out_exception;
  logic [4:0]  busy_tag, out_tag;
  logic [31:0] out_result;

  logic        in_ready_2, busy_2, out_valid_2, out_exception_2;
  logic [4:0]  busy_tag_2, out_tag_2;
  logic [31:0] out_result_2;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  pipelined_multdiv_unit #(.WIDTH(32), .TAG_W(5), .STEPS_PER_CYCLE(1)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .flush(flush),
    .busy(busy), .busy_tag(busy_tag), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_tag(out_tag), .out_exception(out_exception)
  );

  pipelined_multdiv_unit #(.WIDTH(32), .TAG_W(5), .STEPS_PER_CYCLE(2)) dut_2 (
    .clock(clock), .reset(reset), .in_valid(in_valid_2), .in_ready(in_ready_2),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .flush(flush),
    .busy(busy_2), .busy_tag(busy_tag_2), .out_valid(out_valid_2), .out_ready(out_ready_2),
    .out_result(out_result_2), .out_tag(out_tag_2), .out_exception(out_exception_2)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drain(input string name);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({name, "_drain_vld"}, out_valid, 1'b0);
    check({name, "_drain_rdy"}, in_ready, 1'b1);
  endtask

  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] tag, input int lat,
                        input int hold, input logic [31:0] exp_res, input logic exp_exc);
    logic early, tag_bad, unstable;
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_tag = tag;
    tick();
    in_valid = 1'b0;
    early   = out_valid;
    tag_bad = (busy_tag !== tag) || (busy !== 1'b1);
    for (int i = 1; i < lat; i++) begin
      tick();
      early   = early | out_valid;
      tag_bad = tag_bad | (busy_tag !== tag);
    end
    check({name, "_early"}, early, 1'b0);
    check({name, "_busytag"}, tag_bad, 1'b0);
    tick();
    check({name, "_vld"}, out_valid, 1'b1);
    check({name, "_res"}, out_result, exp_res);
    check({name, "_tag"}, out_tag, tag);
    check({name, "_exc"}, out_exception, exp_exc);
    unstable = 1'b0;
    for (int i = 0; i < hold; i++) begin
      tick();
      if (out_valid !== 1'b1 || out_result !== exp_res || out_tag !== tag ||
          out_exception !== exp_exc || in_ready !== 1'b0 || busy !== 1'b1)
        unstable = 1'b1;
    end
    if (hold > 0) check({name, "_hold"}, unstable, 1'b0);
    drain(name);
  endtask

  task automatic check_idle(input string name);
    check({name, "_rdy"}, in_ready, 1'b1);
    check({name, "_busy"}, busy, 1'b0);
    check({name, "_btag"}, busy_tag, 5'd0);
    check({name, "_vld"}, out_valid, 1'b0);
    check({name, "_res"}, out_result, 32'd0);
    check({name, "_tag"}, out_tag, 5'd0);
    check({name, "_exc"}, out_exception, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    reset = 1'b1; in_valid = 1'b0; in_valid_2 = 1'b0; in_op = 2'b00;
    in_a = '0; in_b = '0; in_tag = '0; flush = 1'b0; out_ready = 1'b0; out_ready_2 = 1'b0;
    tick(); tick();
    reset = 1'b0;
    check_idle("reset");

    run_op("mul_7_m6",   2'b01, 32'd7,          32'hFFFF_FFFA, 5'd3, 33, 0, 32'hFFFF_FFD6, 1'b0);
    run_op("mul_ovf",    2'b01, 32'h0001_0000,  32'h0001_0000, 5'd1, 33, 0, 32'h0000_0000, 1'b1);
    run_op("mul_min_1",  2'b01, 32'h8000_0000,  32'd1,         5'd2, 33, 0, 32'h8000_0000, 1'b0);
    run_op("mul_m3_m5",  2'b01, 32'hFFFF_FFFD,  32'hFFFF_FFFB, 5'd6, 33, 0, 32'd15,        1'b0);
    run_op("div_m7_2",   2'b10, 32'hFFFF_FFF9,  32'd2,         5'd4, 33, 0, 32'hFFFF_FFFD, 1'b0);
    run_op("div_min_m1", 2'b10, 32'h8000_0000,  32'hFFFF_FFFF, 5'd5, 33, 0, 32'h8000_0000, 1'b1);
    run_op("div_5_0",    2'b10, 32'd5,          32'd0,         5'd8, 1,  0, 32'd0,         1'b1);
    run_op("bp_div_9_3", 2'b10, 32'd9,          32'd3,         5'd10, 33, 10, 32'd3,       1'b0);

    // Illegal op is ignored.
    in_valid = 1'b1; in_op = 2'b11; in_a = 32'd4; in_b = 32'd4; in_tag = 5'd9;
    tick();
    in_valid = 1'b0;
    check("ill_rdy", in_ready, 1'b1);
    check("ill_busy", busy, 1'b0);

    // Flush in IDLE blocks acceptance.
    in_valid = 1'b1; in_op = 2'b01; flush = 1'b1;
    tick();
    in_valid = 1'b0; flush = 1'b0;
    check("flush_idle_busy", busy, 1'b0);

    // Flush at edge 10 of a MULT.
    in_valid = 1'b1; in_op = 2'b01; in_a = 32'd123; in_b = 32'd456; in_tag = 5'd7;
    tick();
    in_valid = 1'b0;
    for (int i = 1; i < 10; i++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check_idle("flush");
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      seen = seen | out_valid;
    end
    check("flush_no_vld", seen, 1'b0);
    run_op("post_flush_div", 2'b10, 32'd9, 32'd3, 5'd11, 33, 0, 32'd3, 1'b0);

    // Reset mid-run.
    in_valid = 1'b1; in_op = 2'b01; in_a = 32'd55; in_b = 32'd66; in_tag = 5'd12;
    tick();
    in_valid = 1'b0;
    for (int i = 1; i < 6; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_idle("mid_reset");
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      seen = seen | out_valid;
    end
    check("mid_reset_no_vld", seen, 1'b0);

    // Two steps per cycle: DIV 100/7 after edge 17.
    in_valid_2 = 1'b1; in_op = 2'b10; in_a = 32'd100; in_b = 32'd7; in_tag = 5'd9;
    tick();
    in_valid_2 = 1'b0;
    seen = out_valid_2;
    for (int i = 1; i < 17; i++) begin
      tick();
      seen = seen | out_valid_2;
    end
    check("s2_early", seen, 1'b0);
    tick();
    check("s2_vld", out_valid_2, 1'b1);
    check("s2_res", out_result_2, 32'd14);
    check("s2_tag", out_tag_2, 5'd9);
    check("s2_exc", out_exception_2, 1'b0);
    out_ready_2 = 1'b1;
    tick();
    out_ready_2 = 1'b0;
    check("s2_drain_vld", out_valid_2, 1'b0);
    check("s2_drain_rdy", in_ready_2, 1'b1);
    check("s2_drain_busy", busy_2, 1'b0);
    check("s2_drain_btag", busy_tag_2, 5'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
